msg_sequencer: RTL and testbench
================================

# msg_sequencer

Sequences one stored message from the ROM bank out through the serial transmitter. On a write strobe it latches which switch-selected ROM to play and walks the shared ROM address from 0 to MSG_LEN-1. For each byte it loads the transmit data, pulses the transmitter start and waits for the transmitter to finish before advancing. It sits between the switch/holder logic, the four ROMs and `cereal`, and replaces the free-running address counter with a handshaked schedule.

## Interface
- `ADDR_W`, default 4: ROM address width.
- `MSG_LEN`, default 13: bytes per message, 1..2^ADDR_W.
- `ACK_TIMEOUT`, default 15: cycles to wait for `tx_busy` to rise after a start pulse.

- `sysclk`  in  1  the single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `write`  in  1  play request; only its rising edge is used.
- `sw1`..`sw4`  in  1 each  message select; sw1 has highest priority.
- `rom1`..`rom4`  in  8 each  data from the ROMs, combinational on `rom_addr`.
- `tx_busy`  in  1  transmitter status; high while a byte is shifting.
- `rom_addr`  out  ADDR_W  shared ROM address.
- `tx_data`  out  8  byte to transmit; held stable from the FETCH cycle until the next FETCH.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last byte completes.
- `err`  out  1  sticky ack-timeout flag; cleared by the next accepted write.

## Operation
- Reset values: state IDLE, `rom_addr`=0, `tx_data`=0x00, `tx_start`=0, `busy`=0, `done`=0, `err`=0, latched select=none, `write_q`=0.
- Edge detect: `write_q` is registered `write`; a rising edge is `write & ~write_q`.
- IDLE → FETCH when there is a rising edge and at least one switch is high. On that transition:
  - The select is latched as the highest-priority active switch.
  - `rom_addr` is 0.
  - `err` is cleared.
  - An edge with no switch high is ignored.
- FETCH (1 cycle): `tx_data` ← latched ROM's data at `rom_addr`. Next state is START.
- START (1 cycle): `tx_start`=1, ack counter cleared. Next state is WAIT_ACK.
- WAIT_ACK:
  - `tx_busy`=1 → WAIT_DONE.
  - If the counter reaches ACK_TIMEOUT first: set `err`, go to IDLE, `rom_addr`←0, no `done` pulse.
- WAIT_DONE: waits for `tx_busy`=0.
  - If `rom_addr`==MSG_LEN-1: pulse `done`, `rom_addr`←0, go to IDLE.
  - Otherwise `rom_addr`←`rom_addr`+1, go to FETCH.
- Switch changes during a message have no effect; the latched select holds until IDLE.
- Write edges while `busy`=1 are ignored, except as stated under Configuration.
- `rom_addr` never exceeds MSG_LEN-1. The increment is ADDR_W-bit, and wrap is by compare, not overflow.
- Asynchronous reset in any state returns all outputs to their reset values immediately. A partially sent message is abandoned.

## Timing
- Rising edge sampled at clock edge k: state is FETCH in cycle k+1 and `tx_data` is valid from edge k+2. `tx_start` is high for exactly cycle k+2.
- Per-byte overhead beyond transmitter busy time is 4 cycles: FETCH, START, the ack cycle, and the done-detect cycle.
- `done` is high for one cycle, coincident with the first IDLE cycle. `busy` falls in that same cycle.
- `tx_start` never asserts while `tx_busy`=1 as seen in the same cycle.
- The ACK_TIMEOUT count starts in the first WAIT_ACK cycle. The timeout fires when the count equals ACK_TIMEOUT while `tx_busy` is still 0.

## Configuration
- `MSG_SEQ_LOOP_EN`: with the macro defined, the message repeats:
  - After the last byte, go to FETCH with `rom_addr`←0 instead of IDLE, and pulse `done` each pass.
  - A rising edge on `write` while `busy` stops the loop at the end of the current byte (after WAIT_DONE). The block then returns to IDLE without a `done` pulse.
  - Timeout behaviour is unchanged.
- Without the macro: single-shot, and write edges while busy are ignored.

## Test plan
- Reset mid-message (assert `reset_n`=0 during WAIT_DONE) → all outputs at reset values immediately, IDLE, `rom_addr`=0.
- sw2=1, write pulse, transmitter model busy 10 cycles per byte:
  - 13 `tx_start` pulses, with `tx_data` equal to rom2[0..12] in order.
  - `done` pulses once after byte 12; `rom_addr` returns to 0.
- sw1=sw3=1, write pulse → rom1 bytes are sent. Toggling sw1 low mid-message → rom1 bytes continue.
- No switch high, write pulse → stays IDLE, `busy`=0, no `tx_start`. A second write edge during busy → ignored, exactly 13 bytes sent.
- `tx_busy` held 0 → `err`=1 at ACK_TIMEOUT=15 cycles after START, IDLE, no `done`. The next valid write clears `err`.
- With `MSG_SEQ_LOOP_EN` defined: the message repeats with `done` each pass. A write edge during byte 5 of pass 2 → byte 5 finishes, then IDLE with no `done`.

Source files
------------

// File: rtl/msg_sequencer_if.sv
// Bundle of the sequencer's request, ROM-bank and transmitter handshake signals.
// master: the sequencer side; slave: the switch/ROM/transmitter environment.
interface msg_sequencer_if #(
   parameter int ADDR_W = 4
) ();
   logic              write;
   logic              sw1;
   logic              sw2;
   logic              sw3;
   logic              sw4;
   logic [7:0]        rom1;
   logic [7:0]        rom2;
   logic [7:0]        rom3;
   logic [7:0]        rom4;
   logic              tx_busy;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  write, sw1, sw2, sw3, sw4, rom1, rom2, rom3, rom4, tx_busy,
      output rom_addr, tx_data, tx_start, busy, done, err
   );

   modport slave (
      output write, sw1, sw2, sw3, sw4, rom1, rom2, rom3, rom4, tx_busy,
      input  rom_addr, tx_data, tx_start, busy, done, err
   );
endinterface

// File: rtl/msg_sequencer.sv
// Plays one switch-selected ROM message byte by byte through a handshaked serial transmitter.
// Define MSG_SEQ_LOOP_EN to repeat the message until a write edge arrives while busy.
module msg_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int MSG_LEN     = 13,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               sysclk,
   input  logic               reset_n,
   msg_sequencer_if.master    bus
);
   typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_ACK, WAIT_DONE} state_t;

   localparam int                CNT_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
   localparam logic [CNT_W-1:0]  ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [3:0]        sel_q, sel_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
`ifdef MSG_SEQ_LOOP_EN
   logic              stop_q, stop_d;
`endif

   logic              write_edge;
   logic [3:0]        sw_pick;
   logic [7:0]        rom_data;

   assign write_edge = bus.write & ~write_q;

   // One-hot select of the highest-priority active switch; all-zero means none.
   always_comb begin
      sw_pick = 4'b0000;
      if      (bus.sw1) sw_pick = 4'b0001;
      else if (bus.sw2) sw_pick = 4'b0010;
      else if (bus.sw3) sw_pick = 4'b0100;
      else if (bus.sw4) sw_pick = 4'b1000;
   end

   always_comb begin
      case (sel_q)
         4'b0001: rom_data = bus.rom1;
         4'b0010: rom_data = bus.rom2;
         4'b0100: rom_data = bus.rom3;
         4'b1000: rom_data = bus.rom4;
         default: rom_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      write_d    = bus.write;
      rom_addr_d = rom_addr_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      ack_cnt_d  = ack_cnt_q;
`ifdef MSG_SEQ_LOOP_EN
      stop_d     = stop_q | (write_edge & (state_q != IDLE));
`endif
      case (state_q)
         IDLE: begin
            if (write_edge && (sw_pick != 4'b0000)) begin
               state_d    = FETCH;
               sel_d      = sw_pick;
               rom_addr_d = '0;
               err_d      = 1'b0;
            end
         end
         FETCH: begin
            tx_data_d  = rom_data;
            tx_start_d = 1'b1;
            state_d    = START;
         end
         START: begin
            ack_cnt_d = '0;
            state_d   = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else if (ack_cnt_q == ACK_LAST) begin
               err_d      = 1'b1;
               rom_addr_d = '0;
               state_d    = IDLE;
            end else begin
               ack_cnt_d = ack_cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
`ifdef MSG_SEQ_LOOP_EN
               // A stop request wins over both advancing and the end-of-pass done pulse.
               if (stop_q || write_edge) begin
                  rom_addr_d = '0;
                  state_d    = IDLE;
               end else if (rom_addr_q == LAST_ADDR) begin
                  done_d     = 1'b1;
                  rom_addr_d = '0;
                  state_d    = FETCH;
               end else begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d    = FETCH;
               end
`else
               if (rom_addr_q == LAST_ADDR) begin
                  done_d     = 1'b1;
                  rom_addr_d = '0;
                  state_d    = IDLE;
               end else begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d    = FETCH;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) begin
         sel_d = 4'b0000;
`ifdef MSG_SEQ_LOOP_EN
         stop_d = 1'b0;
`endif
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sel_q      <= 4'b0000;
         write_q    <= 1'b0;
         rom_addr_q <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_cnt_q  <= '0;
`ifdef MSG_SEQ_LOOP_EN
         stop_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         write_q    <= write_d;
         rom_addr_q <= rom_addr_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ack_cnt_q  <= ack_cnt_d;
`ifdef MSG_SEQ_LOOP_EN
         stop_q     <= stop_d;
`endif
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_msg_sequencer.sv
// Directed bench for msg_sequencer: ROM and transmitter models plus a byte scoreboard.
module tb_msg_sequencer;
   localparam int ADDR_W      = 4;
   localparam int MSG_LEN     = 13;
   localparam int ACK_TIMEOUT = 15;
   localparam int TX_CYC      = 10;

   logic sysclk  = 1'b0;
   logic reset_n = 1'b0;
   logic tx_en   = 1'b1;
   int   tx_cnt;
   int   n_assert  = 0;
   int   n_fail    = 0;
   int   start_cnt = 0;
   int   done_cnt  = 0;
   logic [7:0] exp_q[$];

   msg_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   msg_sequencer #(
      .ADDR_W(ADDR_W), .MSG_LEN(MSG_LEN), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .sysclk(sysclk), .reset_n(reset_n), .bus(bus)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic [7:0] rom_val(input int k, input logic [ADDR_W-1:0] a);
      return 8'(k * 37 + int'(a) * 11 + 3);
   endfunction

   assign bus.rom1    = rom_val(1, bus.rom_addr);
   assign bus.rom2    = rom_val(2, bus.rom_addr);
   assign bus.rom3    = rom_val(3, bus.rom_addr);
   assign bus.rom4    = rom_val(4, bus.rom_addr);
   assign bus.tx_busy = (tx_cnt != 0);

   // Transmitter: busy for TX_CYC cycles after each accepted start pulse.
   always @(posedge sysclk or negedge reset_n) begin
      if (!reset_n)                  tx_cnt <= 0;
      else if (bus.tx_start && tx_en) tx_cnt <= TX_CYC;
      else if (tx_cnt != 0)           tx_cnt <= tx_cnt - 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge sysclk) begin
      if (reset_n) begin
         if (bus.tx_start === 1'b1) begin
            start_cnt++;
            chk("start_while_txbusy", bus.tx_busy, 0);
            chk("sb_has_entry", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) chk("tx_data", bus.tx_data, exp_q.pop_front());
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
`ifdef MSG_SEQ_LOOP_EN
            chk("done_busy", bus.busy, 1);
`else
            chk("done_busy", bus.busy, 0);
`endif
            chk("done_addr", bus.rom_addr, 0);
         end
      end
   end

   task automatic tick();
      @(negedge sysclk);
   endtask

   task automatic pulse_write();
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
   endtask

   task automatic push_msg(input int k, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(rom_val(k, ADDR_W'(i)));
   endtask

   task automatic wait_done(input int d0, input int bound);
      for (int i = 0; i < bound && done_cnt == d0; i++) tick();
      chk("done_seen", done_cnt - d0, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rom_addr"}, bus.rom_addr, 0);
      chk({tag, "_tx_data"},  bus.tx_data, 0);
      chk({tag, "_tx_start"}, bus.tx_start, 0);
      chk({tag, "_busy"},     bus.busy, 0);
      chk({tag, "_done"},     bus.done, 0);
      chk({tag, "_err"},      bus.err, 0);
   endtask

   initial begin
      int s0;
      int d0;
      bus.write = 1'b0;
      bus.sw1 = 1'b0; bus.sw2 = 1'b0; bus.sw3 = 1'b0; bus.sw4 = 1'b0;
      reset_n = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("rst");
      reset_n = 1'b1;
      tick();

      // Write edge with no switch selected is ignored.
      s0 = start_cnt;
      pulse_write();
      repeat (5) tick();
      chk("nosw_busy", bus.busy, 0);
      chk("nosw_starts", start_cnt - s0, 0);

      // Transmitter never acknowledges: timeout after ACK_TIMEOUT wait cycles.
      bus.sw4 = 1'b1;
      tx_en = 1'b0;
      push_msg(4, 1);
      d0 = done_cnt;
      pulse_write();
      chk("to_busy_fetch", bus.busy, 1);
      tick();
      chk("to_start", bus.tx_start, 1);
      for (int n = 1; n <= ACK_TIMEOUT; n++) tick();
      chk("to_err_early", bus.err, 0);
      chk("to_busy_early", bus.busy, 1);
      tick();
      chk("to_err", bus.err, 1);
      chk("to_idle", bus.busy, 0);
      chk("to_addr", bus.rom_addr, 0);
      chk("to_no_done", done_cnt - d0, 0);
      repeat (3) tick();
      chk("to_err_sticky", bus.err, 1);
      chk("to_sb_empty", exp_q.size(), 0);
      bus.sw4 = 1'b0;
      tx_en = 1'b1;

`ifndef MSG_SEQ_LOOP_EN
      // Full message from rom2; a second write edge mid-message is ignored.
      bus.sw2 = 1'b1;
      push_msg(2, MSG_LEN);
      s0 = start_cnt;
      d0 = done_cnt;
      pulse_write();
      chk("m2_busy", bus.busy, 1);
      chk("m2_start_early", bus.tx_start, 0);
      chk("m2_err_cleared", bus.err, 0);
      tick();
      chk("m2_start", bus.tx_start, 1);
      chk("m2_first_byte", bus.tx_data, rom_val(2, 0));
      repeat (20) tick();
      pulse_write();
      wait_done(d0, 3000);
      chk("m2_starts", start_cnt - s0, MSG_LEN);
      chk("m2_idle", bus.busy, 0);
      chk("m2_addr", bus.rom_addr, 0);
      chk("m2_sb_empty", exp_q.size(), 0);
      repeat (20) tick();
      chk("m2_no_extra", start_cnt - s0, MSG_LEN);
      bus.sw2 = 1'b0;

      // sw1 has priority over sw3, and dropping sw1 mid-message changes nothing.
      bus.sw1 = 1'b1;
      bus.sw3 = 1'b1;
      push_msg(1, MSG_LEN);
      s0 = start_cnt;
      d0 = done_cnt;
      pulse_write();
      for (int i = 0; i < 500 && start_cnt - s0 < 3; i++) tick();
      bus.sw1 = 1'b0;
      wait_done(d0, 3000);
      chk("m1_starts", start_cnt - s0, MSG_LEN);
      chk("m1_sb_empty", exp_q.size(), 0);
      bus.sw3 = 1'b0;
`else
      // Looping: pass 1 completes with done, pass 2 stopped during byte 5.
      bus.sw2 = 1'b1;
      push_msg(2, MSG_LEN);
      push_msg(2, 6);
      s0 = start_cnt;
      d0 = done_cnt;
      pulse_write();
      chk("lp_err_cleared", bus.err, 0);
      chk("lp_busy", bus.busy, 1);
      for (int i = 0; i < 5000 && start_cnt - s0 < MSG_LEN + 6; i++) tick();
      repeat (3) tick();
      pulse_write();
      for (int i = 0; i < 500 && bus.busy; i++) tick();
      chk("lp_idle", bus.busy, 0);
      chk("lp_done_once", done_cnt - d0, 1);
      chk("lp_starts", start_cnt - s0, MSG_LEN + 6);
      chk("lp_sb_empty", exp_q.size(), 0);
      repeat (20) tick();
      chk("lp_no_extra", start_cnt - s0, MSG_LEN + 6);
      bus.sw2 = 1'b0;
`endif

      // Asynchronous reset while a byte is shifting abandons the message.
      bus.sw3 = 1'b1;
      push_msg(3, MSG_LEN);
      s0 = start_cnt;
      pulse_write();
      for (int i = 0; i < 500 && start_cnt - s0 < 2; i++) tick();
      repeat (4) tick();
      chk("mid_txbusy", bus.tx_busy, 1);
      chk("mid_addr", bus.rom_addr, 1);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("arst");
      exp_q.delete();
      repeat (3) tick();
      chk("arst_hold_busy", bus.busy, 0);
      reset_n = 1'b1;
      s0 = start_cnt;
      repeat (10) tick();
      chk("arst_no_start", start_cnt - s0, 0);
      chk("arst_idle", bus.busy, 0);
      bus.sw3 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
